// File: rtl/vga_pkg.sv
// Shared constants for the VGA port write queue: port map, FIFO depth,
// FSM encodings, status-byte layout and the window-decode helpers.
package vga_pkg;

    localparam logic [7:0] PORT_VGA_BASE      = 8'h10;
    localparam int         PORT_VGA_NUM       = 8;
    localparam logic [7:0] PORT_VGA_STATUS    = 8'h1F;
    localparam int         VGA_WRQ_DEPTH_LOG2 = 4;

    localparam logic ST_IDLE  = 1'b0;
    localparam logic ST_DRAIN = 1'b1;

    localparam int STAT_OVERFLOW_BIT = 7;
    localparam int STAT_FULL_BIT     = 6;
    localparam int STAT_EMPTY_BIT    = 5;
    localparam int STAT_COUNT_W      = 5;

    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wrq_entry_t;

    // Widened to 9 bits so a window ending at 8'hFF cannot wrap.
    function automatic logic in_window(input logic [7:0] port_id,
                                       input logic [7:0] base,
                                       input int         num);
        logic [8:0] lo;
        logic [8:0] hi;
        lo = {1'b0, base};
        hi = lo + 9'(num);
        return ({1'b0, port_id} >= lo) && ({1'b0, port_id} < hi);
    endfunction

    function automatic logic [7:0] status_byte(input logic                    overflow,
                                               input logic                    full,
                                               input logic                    empty,
                                               input logic [STAT_COUNT_W-1:0] count);
        logic [7:0] s;
        s = '0;
        s[STAT_OVERFLOW_BIT]  = overflow;
        s[STAT_FULL_BIT]      = full;
        s[STAT_EMPTY_BIT]     = empty;
        s[STAT_COUNT_W-1:0]   = count;
        return s;
    endfunction

endpackage

// File: rtl/vga_wrq_fifo.sv
// Circular FIFO for queued VGA port writes: synchronous-write RAM with
// asynchronous read of the head, extra-MSB pointers for full/empty.
module vga_wrq_fifo
    import vga_pkg::*;
#(
    parameter int DEPTH_LOG2 = VGA_WRQ_DEPTH_LOG2,
    parameter int WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  logic                  pop,
    input  logic [WIDTH-1:0]      wr_data,
    output logic [WIDTH-1:0]      rd_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2-1:0] count
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [DEPTH_LOG2:0] wr_ptr;
    logic [DEPTH_LOG2:0] rd_ptr;
    logic [WIDTH-1:0]    mem [DEPTH];
    logic                do_push;
    logic                do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[DEPTH_LOG2] != rd_ptr[DEPTH_LOG2]) &&
                   (wr_ptr[DEPTH_LOG2-1:0] == rd_ptr[DEPTH_LOG2-1:0]);
    // Index-width difference: a full FIFO reads back as zero here.
    assign count = wr_ptr[DEPTH_LOG2-1:0] - rd_ptr[DEPTH_LOG2-1:0];

    // A pop frees the slot a full-FIFO push lands in, so both proceed together.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign rd_data = mem[rd_ptr[DEPTH_LOG2-1:0]];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // NOTE: the storage array has no reset; the pointers alone define which
    // entries are valid, and leaving it unreset lets it map onto RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;
    end

endmodule

// File: rtl/vga_port_write_queue.sv
// Buffers PicoBlaze writes to the VGA port window and replays them to the
// pointer stage during VSync low. Optional macro: VGA_WRQ_DROP_COUNT_EN.
module vga_port_write_queue
    import vga_pkg::*;
#(
    parameter logic [7:0] BASE_PORT   = PORT_VGA_BASE,
    parameter int         NUM_PORTS   = PORT_VGA_NUM,
    parameter logic [7:0] STATUS_PORT = PORT_VGA_STATUS,
    parameter int         DEPTH_LOG2  = VGA_WRQ_DEPTH_LOG2
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] Port_ID,
    input  logic [7:0] IN_DATA,
    input  logic       Write_Strobe,
    input  logic       Read_Strobe,
    input  logic       VSync,
    output logic [7:0] OUT_DATA,
    output logic [7:0] MemAddrOut,
    output logic [7:0] MemDataOut,
    output logic       MemWrite
);

    localparam logic [7:0] DROP_PORT = STATUS_PORT + 8'd1;

    logic                  state;
    logic                  state_next;
    logic                  push_req;
    logic                  status_wr;
    logic                  pop;
    logic                  drop;
    logic                  overflow;
    logic [7:0]            drop_count;
    logic [7:0]            status;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [DEPTH_LOG2-1:0] fifo_count;
    wrq_entry_t            push_entry;
    wrq_entry_t            head_entry;

    assign push_req   = Write_Strobe && in_window(Port_ID, BASE_PORT, NUM_PORTS);
    assign status_wr  = Write_Strobe && (Port_ID == STATUS_PORT);
    assign push_entry = '{addr: Port_ID, data: IN_DATA};

    // Popping is gated directly by VSync so a rise stops replay on that edge.
    assign pop  = (state == ST_DRAIN) && !VSync && !fifo_empty;
    assign drop = push_req && fifo_full && !pop;

    vga_wrq_fifo #(
        .DEPTH_LOG2 (DEPTH_LOG2),
        .WIDTH      (16)
    ) u_fifo (
        .clk     (CLK),
        .rst     (RESET),
        .push    (push_req),
        .pop     (pop),
        .wr_data (push_entry),
        .rd_data (head_entry),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    always_comb begin
        state_next = state;
        if (state == ST_IDLE) begin
            if (!VSync && !fifo_empty) state_next = ST_DRAIN;
        end else begin
            if (VSync || fifo_empty) state_next = ST_IDLE;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) state <= ST_IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            MemWrite   <= 1'b0;
            MemAddrOut <= 8'h00;
            MemDataOut <= 8'h00;
        end else begin
            MemWrite <= pop;
            if (pop) begin
                MemAddrOut <= head_entry.addr;
                MemDataOut <= head_entry.data;
            end
        end
    end

    // A drop in the same cycle as a clear leaves overflow set.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET)          overflow <= 1'b0;
        else if (drop)      overflow <= 1'b1;
        else if (status_wr) overflow <= 1'b0;
    end

`ifdef VGA_WRQ_DROP_COUNT_EN
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            drop_count <= 8'h00;
        end else if (drop) begin
            if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
        end else if (status_wr) begin
            drop_count <= 8'h00;
        end
    end
`else
    assign drop_count = 8'h00;
`endif

    assign status = status_byte(overflow, fifo_full, fifo_empty, STAT_COUNT_W'(fifo_count));

    // NOTE: OUT_DATA gets a default before any branch so no path through the
    // block leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        OUT_DATA = 8'h00;
        if (Read_Strobe) begin
            if (Port_ID == STATUS_PORT)    OUT_DATA = status;
            else if (Port_ID == DROP_PORT) OUT_DATA = drop_count;
        end
    end

endmodule

// File: tb/tb_vga_port_write_queue.sv
// Scoreboard bench for vga_port_write_queue: expected replays are queued as
// writes are driven and compared as MemWrite pulses appear.
module tb_vga_port_write_queue;

    localparam logic [7:0] STATUS = 8'h1F;
    localparam logic [7:0] DROP   = 8'h20;

    logic       CLK = 1'b0;
    logic       RESET = 1'b0;
    logic [7:0] Port_ID = 8'h00;
    logic [7:0] IN_DATA = 8'h00;
    logic       Write_Strobe = 1'b0;
    logic       Read_Strobe = 1'b0;
    logic       VSync = 1'b1;
    logic [7:0] OUT_DATA;
    logic [7:0] MemAddrOut;
    logic [7:0] MemDataOut;
    logic       MemWrite;

    int          n_checks = 0;
    int          n_fail = 0;
    int          n_writes = 0;
    int          n_rises = 0;
    logic        prev_mw = 1'b0;
    logic [15:0] sb[$];

    vga_port_write_queue dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .Port_ID      (Port_ID),
        .IN_DATA      (IN_DATA),
        .Write_Strobe (Write_Strobe),
        .Read_Strobe  (Read_Strobe),
        .VSync        (VSync),
        .OUT_DATA     (OUT_DATA),
        .MemAddrOut   (MemAddrOut),
        .MemDataOut   (MemDataOut),
        .MemWrite     (MemWrite)
    );

    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

    // One clock: observe outputs on the falling edge and score any replay.
    task automatic cycle();
        logic [15:0] exp;
        @(negedge CLK);
        if (MemWrite === 1'b1) begin
            n_writes++;
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL replay_unexpected: got %h/%h, required no MemWrite", MemAddrOut, MemDataOut);
            end else begin
                exp = sb.pop_front();
                if ({MemAddrOut, MemDataOut} !== exp) begin
                    n_fail++;
                    $display("FAIL replay_order: got %h/%h, required %h/%h",
                             MemAddrOut, MemDataOut, exp[15:8], exp[7:0]);
                end
            end
        end
        if (MemWrite === 1'b1 && prev_mw !== 1'b1) n_rises++;
        prev_mw = MemWrite;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic write_port(input logic [7:0] p, input logic [7:0] d, input bit queued);
        Port_ID = p;
        IN_DATA = d;
        Write_Strobe = 1'b1;
        if (queued) sb.push_back({p, d});
        cycle();
        Write_Strobe = 1'b0;
        Port_ID = 8'h00;
    endtask

    task automatic read_port(input logic [7:0] p, output logic [7:0] v);
        cycle();
        Port_ID = p;
        Read_Strobe = 1'b1;
        #1;
        v = OUT_DATA;
        Read_Strobe = 1'b0;
        Port_ID = 8'h00;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        #3 RESET = 1'b1;
        @(negedge CLK);
        n_checks++;
        if (MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_memwrite: got %b, required 0", MemWrite);
        end
        n_checks++;
        if ({MemAddrOut, MemDataOut} !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h/%h, required 00/00", MemAddrOut, MemDataOut);
        end
        RESET = 1'b0;
        VSync = 1'b0;
        n_writes = 0;
        cycles(6);
        n_checks++;
        if (n_writes != 0) begin
            n_fail++;
            $display("FAIL idle_no_replay: got %0d writes, required 0", n_writes);
        end
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL reset_status: got %b, required 00100000", v);
        end
        VSync = 1'b1;
    endtask

    task automatic test_back_to_back();
        logic [7:0] v;
        write_port(8'h11, 8'hAA, 1'b1);
        write_port(8'h12, 8'h55, 1'b1);
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'h02) begin
            n_fail++;
            $display("FAIL queued_status: got %b, required 00000010", v);
        end
        n_writes = 0;
        n_rises = 0;
        VSync = 1'b0;
        cycles(6);
        n_checks++;
        if (n_writes != 2 || n_rises != 1) begin
            n_fail++;
            $display("FAIL back_to_back: got %0d writes in %0d pulses, required 2 in 1", n_writes, n_rises);
        end
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL drained_status: got %b, required 00100000", v);
        end
        VSync = 1'b1;
    endtask

    task automatic test_window_decode();
        logic [7:0] v;
        Port_ID = STATUS;
        #1;
        n_checks++;
        if (OUT_DATA !== 8'h00) begin
            n_fail++;
            $display("FAIL out_data_no_strobe: got %h, required 00", OUT_DATA);
        end
        write_port(8'h30, 8'h01, 1'b0);
        write_port(STATUS, 8'h02, 1'b0);
        write_port(8'h0F, 8'h03, 1'b0);
        write_port(8'h18, 8'h04, 1'b0);
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL ignored_ports: got %b, required 00100000", v);
        end
        write_port(8'h17, 8'h3C, 1'b1);
        write_port(8'h10, 8'hC3, 1'b1);
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'h02) begin
            n_fail++;
            $display("FAIL window_edges: got %b, required 00000010", v);
        end
        n_writes = 0;
        VSync = 1'b0;
        cycles(6);
        VSync = 1'b1;
        n_checks++;
        if (n_writes != 2) begin
            n_fail++;
            $display("FAIL window_edges_replay: got %0d writes, required 2", n_writes);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] v;
        for (int i = 0; i < 17; i++) write_port(8'h10, 8'(i), i < 16);
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b1100_0000) begin
            n_fail++;
            $display("FAIL overflow_status: got %b, required 11000000", v);
        end
        read_port(DROP, v);
        n_checks++;
`ifdef VGA_WRQ_DROP_COUNT_EN
        if (v !== 8'd1) begin
`else
        if (v !== 8'd0) begin
`endif
            n_fail++;
            $display("FAIL drop_count_one: got %0d, required count of one drop when enabled else 0", v);
        end
        write_port(STATUS, 8'h00, 1'b0);
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0100_0000) begin
            n_fail++;
            $display("FAIL overflow_clear: got %b, required 01000000", v);
        end
        // Enter DRAIN, then write while full on the first popping edge.
        n_writes = 0;
        VSync = 1'b0;
        cycle();
        write_port(8'h11, 8'hEE, 1'b1);
        cycles(20);
        VSync = 1'b1;
        n_checks++;
        if (n_writes != 17 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL push_pop_full: got %0d writes, %0d pending, required 17 and 0", n_writes, sb.size());
        end
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL push_pop_full_status: got %b, required 00100000", v);
        end
    endtask

    task automatic test_partial_window();
        logic [7:0] v;
        for (int i = 0; i < 10; i++) write_port(8'h13, 8'h40 + 8'(i), 1'b1);
        n_writes = 0;
        // One edge to enter DRAIN, then four popping edges.
        VSync = 1'b0;
        cycles(5);
        VSync = 1'b1;
        cycles(3);
        n_checks++;
        if (n_writes != 4) begin
            n_fail++;
            $display("FAIL partial_replays: got %0d writes, required 4", n_writes);
        end
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'h06) begin
            n_fail++;
            $display("FAIL partial_status: got %b, required 00000110", v);
        end
        VSync = 1'b0;
        cycles(12);
        VSync = 1'b1;
        n_checks++;
        if (n_writes != 10 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL partial_resume: got %0d writes, %0d pending, required 10 and 0", n_writes, sb.size());
        end
    endtask

    task automatic test_drop_count();
        logic [7:0] v;
        for (int i = 0; i < 16; i++) write_port(8'h14, 8'h80 + 8'(i), 1'b1);
        for (int i = 0; i < 20; i++) write_port(8'h15, 8'(i), 1'b0);
        read_port(DROP, v);
        n_checks++;
`ifdef VGA_WRQ_DROP_COUNT_EN
        if (v !== 8'd20) begin
`else
        if (v !== 8'd0) begin
`endif
            n_fail++;
            $display("FAIL drop_count_20: got %0d, required 20 when enabled else 0", v);
        end
        for (int i = 0; i < 240; i++) write_port(8'h15, 8'(i), 1'b0);
        read_port(DROP, v);
        n_checks++;
`ifdef VGA_WRQ_DROP_COUNT_EN
        if (v !== 8'd255) begin
`else
        if (v !== 8'd0) begin
`endif
            n_fail++;
            $display("FAIL drop_count_saturate: got %0d, required 255 when enabled else 0", v);
        end
        write_port(STATUS, 8'h00, 1'b0);
        read_port(DROP, v);
        n_checks++;
        if (v !== 8'd0) begin
            n_fail++;
            $display("FAIL drop_count_clear: got %0d, required 0", v);
        end
        n_writes = 0;
        VSync = 1'b0;
        cycles(20);
        VSync = 1'b1;
        n_checks++;
        if (n_writes != 16 || sb.size() != 0) begin
            n_fail++;
            $display("FAIL drop_drain: got %0d writes, %0d pending, required 16 and 0", n_writes, sb.size());
        end
    endtask

    task automatic test_reset_during_drain();
        logic [7:0] v;
        for (int i = 0; i < 5; i++) write_port(8'h16, 8'hD0 + 8'(i), 1'b1);
        VSync = 1'b0;
        cycles(3);
        n_checks++;
        if (MemWrite !== 1'b1) begin
            n_fail++;
            $display("FAIL drain_active: got MemWrite %b, required 1", MemWrite);
        end
        #1 RESET = 1'b1;
        #1;
        n_checks++;
        if (MemWrite !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_memwrite: got %b, required 0", MemWrite);
        end
        sb.delete();
        cycles(2);
        RESET = 1'b0;
        n_writes = 0;
        cycles(8);
        n_checks++;
        if (n_writes != 0) begin
            n_fail++;
            $display("FAIL post_reset_replay: got %0d writes, required 0", n_writes);
        end
        read_port(STATUS, v);
        n_checks++;
        if (v !== 8'b0010_0000) begin
            n_fail++;
            $display("FAIL post_reset_status: got %b, required 00100000", v);
        end
        VSync = 1'b1;
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_window_decode();
        test_overflow();
        test_partial_window();
        test_drop_count();
        test_reset_during_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
